nested_rec_fifo: RTL and testbench

- Buffering stage that sits directly upstream of the nested-struct consumer.
- Accepts packed nested records {bar1 a; bar2 b} over a valid/ready handshake and stores them in a small FIFO.
- Presents the head record unpacked into its struct fields for the downstream stage.
- Also reports occupancy and a sticky protocol-error flag.

---
 rtl/nested_rec_pkg.sv | 22 ++
 rtl/nested_rec_ptr.sv | 66 ++++++
 rtl/nested_rec_fifo.sv | 98 +++++++++
 tb/tb_nested_rec_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nested_rec_pkg.sv
// Record types shared by the FIFO and the downstream nested-struct consumer.
// The field order inside rec_t fixes the wire mapping: bit 2 is a.v,
// bits 1:0 are b.{hi,lo}.
package nested_rec_pkg;

    typedef struct packed {
        logic v;
    } bar1;

    typedef struct packed {
        logic hi;
        logic lo;
    } bar2;

    typedef struct packed {
        bar1 a;
        bar2 b;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

endpackage

// File: rtl/nested_rec_ptr.sv
// Read/write pointer and occupancy bookkeeping for nested_rec_fifo.
// Pointers are one bit narrower than the count and wrap naturally modulo DEPTH.
module nested_rec_ptr #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-2:0] wr_ptr,
    output logic [CNT_W-2:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = CNT_W - 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state pointers and count; flush overrides any push or pop.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/nested_rec_fifo.sv
// Small FIFO of packed nested records feeding the nested-struct consumer.
// The head entry is presented unpacked into its fields; in_ready depends only
// on stored occupancy, so there is no combinational path from out_ready.
module nested_rec_fifo
    import nested_rec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_rec,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_a,
    output logic [1:0]       out_b,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam int PTR_W = CNT_W - 1;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty;
    logic             push, pop;

    rec_t mem_q [DEPTH];
    rec_t mem_d [DEPTH];
    rec_t head;

    logic stall_q, stall_d;
    logic err_q, err_d;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    nested_rec_ptr #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Storage write: a flushed cycle discards the incoming record.
    always_comb begin
        mem_d = mem_q;
        if (push && !flush) mem_d[wr_ptr] = rec_t'(in_rec);
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the array is reset so the head fields read all-zero out of reset; it is tiny, so this is cheap.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Head record unpacked through its struct members.
    assign head  = mem_q[rd_ptr];
    assign out_a = head.a.v;
    assign out_b = {head.b.hi, head.b.lo};

    // Protocol tracker: a stalled record withdrawn before acceptance latches err.
    always_comb begin
        stall_d = in_valid && !in_ready;
        err_d   = err_q || (stall_q && !in_valid);
    end

    // Stall and sticky error registers; err clears only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_nested_rec_fifo.sv
// Directed self-checking bench for nested_rec_fifo (DEPTH=4).
module tb_nested_rec_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_rec;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             out_a;
    logic [1:0]       out_b;
    logic [CNT_W-1:0] count;
    logic             err;

    int total = 0;
    int bad   = 0;

    nested_rec_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rec    (in_rec),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards take effect at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [2:0] r);
        in_valid = 1'b1;
        in_rec   = r;
        tick();
        in_valid = 1'b0;
    endtask

    // Check head fields, then pop it.
    task automatic pop_check(input string tag, input logic a, input logic [1:0] b);
        check({tag, "_valid"}, 8'(out_valid), 8'd1);
        check({tag, "_a"}, 8'(out_a), 8'(a));
        check({tag, "_b"}, 8'(out_b), 8'(b));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_rec    = 3'b000;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset / idle
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_in_ready", 8'(in_ready), 8'd1);
        check("rst_count", 8'(count), 8'd0);
        check("rst_out_a", 8'(out_a), 8'd0);
        check("rst_out_b", 8'(out_b), 8'd0);
        check("rst_err", 8'(err), 8'd0);

        // Single record, one-cycle latency, then pop
        push_rec(3'b101);
        check("one_count", 8'(count), 8'd1);
        pop_check("one", 1'b1, 2'b01);
        check("one_count_after_pop", 8'(count), 8'd0);
        check("one_empty", 8'(out_valid), 8'd0);

        // Fill to DEPTH and drain in order
        push_rec(3'b001);
        push_rec(3'b010);
        push_rec(3'b011);
        push_rec(3'b100);
        check("full_count", 8'(count), 8'd4);
        check("full_in_ready", 8'(in_ready), 8'd0);
        pop_check("drain0", 1'b0, 2'b01);
        pop_check("drain1", 1'b0, 2'b10);
        pop_check("drain2", 1'b0, 2'b11);
        pop_check("drain3", 1'b1, 2'b00);
        check("drained_count", 8'(count), 8'd0);

        // Six records across the pointer wrap
        push_rec(3'b110);
        push_rec(3'b111);
        push_rec(3'b000);
        push_rec(3'b101);
        pop_check("wrap0", 1'b1, 2'b10);
        pop_check("wrap1", 1'b1, 2'b11);
        push_rec(3'b011);
        push_rec(3'b010);
        check("wrap_full_count", 8'(count), 8'd4);
        pop_check("wrap2", 1'b0, 2'b00);
        pop_check("wrap3", 1'b1, 2'b01);
        pop_check("wrap4", 1'b0, 2'b11);
        pop_check("wrap5", 1'b0, 2'b10);
        check("wrap_count", 8'(count), 8'd0);

        // Full with push and pop offered together: only the pop happens
        push_rec(3'b001);
        push_rec(3'b010);
        push_rec(3'b011);
        push_rec(3'b100);
        in_valid  = 1'b1;
        in_rec    = 3'b111;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fullpp_count", 8'(count), 8'd3);
        check("fullpp_in_ready", 8'(in_ready), 8'd1);
        // Held record is accepted now that a slot is free
        tick();
        in_valid = 1'b0;
        check("fullpp_refill_count", 8'(count), 8'd4);
        check("fullpp_no_err", 8'(err), 8'd0);
        pop_check("fullpp_head0", 1'b0, 2'b10);
        pop_check("fullpp_head1", 1'b0, 2'b11);
        check("pre_flush_count", 8'(count), 8'd2);

        // Flush with a same-cycle push attempt
        flush    = 1'b1;
        in_valid = 1'b1;
        in_rec   = 3'b011;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 8'(count), 8'd0);
        check("flush_out_valid", 8'(out_valid), 8'd0);
        tick();
        check("flush_still_empty", 8'(out_valid), 8'd0);
        check("flush_count2", 8'(count), 8'd0);

        // Withdraw a stalled record: sticky err survives flush
        push_rec(3'b001);
        push_rec(3'b010);
        push_rec(3'b011);
        push_rec(3'b100);
        in_valid = 1'b1;
        in_rec   = 3'b110;
        tick();
        check("stall_err_clear", 8'(err), 8'd0);
        in_valid = 1'b0;
        tick();
        check("err_set", 8'(err), 8'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("err_after_flush", 8'(err), 8'd1);
        check("count_after_flush", 8'(count), 8'd0);

        // Asynchronous reset mid-stream
        push_rec(3'b111);
        push_rec(3'b101);
        check("pre_rst_count", 8'(count), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_err", 8'(err), 8'd0);
        check("async_rst_count", 8'(count), 8'd0);
        check("async_rst_out_valid", 8'(out_valid), 8'd0);
        check("async_rst_in_ready", 8'(in_ready), 8'd1);
        check("async_rst_out_b", 8'(out_b), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_count", 8'(count), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
